// File: rtl/ex_stage_md.sv
// Execute stage: ALU, branch target, EX/MEM register, and an iterative multiply/divide unit owning HI/LO.
// Optional macro EX_FAST_MUL_EN: mult/multu use a combinational multiplier (one busy cycle); divide unchanged.
module ex_stage_md #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             ex_ready,
  input  logic             flush,
  input  logic             mem_stall,
  input  logic [3:0]       alu_op,
  input  logic             alu_src,
  input  logic             ext_op,
  input  logic             reg_dst,
  input  logic [2:0]       md_op,
  input  logic [CTRLW-1:0] ctrl_in,
  input  logic [XLEN-1:0]  next_pc,
  input  logic [XLEN-1:0]  bus_a,
  input  logic [XLEN-1:0]  bus_b,
  input  logic [15:0]      imm,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  output logic             ex_valid,
  output logic [CTRLW-1:0] ctrl_ex,
  output logic [XLEN-1:0]  alu_out,
  output logic             zero,
  output logic             overflow,
  output logic [XLEN-1:0]  tran_addr,
  output logic [4:0]       regwr,
  output logic [XLEN-1:0]  reg_data,
  output logic             md_busy
);

  localparam int CNTW = $clog2(XLEN);
  localparam int MSB  = XLEN - 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                               input logic signed [XLEN-1:0] a,
                                               input logic signed [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~(a | b);
      4'd6:    r = {{(XLEN-1){1'b0}}, (a < b)};
      4'd7:    r = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      4'd8:    r = b << 16;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic add_sub_ovf(input logic [3:0] op, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] r);
    case (op)
      4'd0:    return (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      4'd1:    return (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      default: return 1'b0;
    endcase
  endfunction

  logic [XLEN-1:0] ext, opnd_b, alu_res, result, hi, lo, mag_a, mag_b;
  logic            ovf_res, accept, md_issue, md_start, md_signed, md_div_op;

  assign ex_ready  = !md_busy && !mem_stall;
  assign accept    = id_valid && ex_ready && !flush;
  assign md_issue  = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign md_start  = accept && md_issue;
  assign md_signed = (md_op == 3'd1) || (md_op == 3'd3);
  assign md_div_op = (md_op == 3'd3) || (md_op == 3'd4);
  assign mag_a     = (md_signed && bus_a[MSB]) ? -bus_a : bus_a;
  assign mag_b     = (md_signed && bus_b[MSB]) ? -bus_b : bus_b;

  assign ext     = ext_op ? XLEN'($signed(imm)) : XLEN'(imm);
  assign opnd_b  = alu_src ? ext : bus_b;
  assign alu_res = alu_calc(alu_op, bus_a, opnd_b);
  assign result  = (md_op == 3'd5) ? hi : (md_op == 3'd6) ? lo : alu_res;
  assign ovf_res = (md_op == 3'd5 || md_op == 3'd6) ? 1'b0 : add_sub_ovf(alu_op, bus_a, opnd_b, alu_res);

  // EX/MEM register: mult/div issue and rejected slots become bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ctrl_ex   <= '0;
      alu_out   <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      tran_addr <= '0;
      regwr     <= '0;
      reg_data  <= '0;
    end else if (!mem_stall) begin
      ex_valid  <= accept && !md_issue;
      ctrl_ex   <= (accept && !md_issue) ? ctrl_in : '0;
      alu_out   <= result;
      zero      <= (result == '0);
      overflow  <= ovf_res;
      tran_addr <= next_pc + (ext << 2);
      regwr     <= reg_dst ? rd : rt;
      reg_data  <= bus_b;
    end
  end

  // Multiply/divide datapath works on magnitudes; signs are restored in FIX
  md_state_t         state;
  logic [CNTW-1:0]   cnt;
  logic [XLEN-1:0]   w_hi, w_lo, mb, quot, rem;
  logic              sign_a, sign_b, div_q;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_mag, prod;

  assign mul_sum   = {1'b0, w_hi} + {1'b0, (mb & {XLEN{w_lo[0]}})};
  assign div_shift = {w_hi, w_lo[MSB]};
  assign div_diff  = div_shift - {1'b0, mb};
`ifdef EX_FAST_MUL_EN
  assign prod_mag  = {{XLEN{1'b0}}, w_lo} * {{XLEN{1'b0}}, mb};
`else
  assign prod_mag  = {w_hi, w_lo};
`endif
  assign prod = (sign_a ^ sign_b) ? -prod_mag : prod_mag;
  assign quot = (mb == '0) ? '1 : ((sign_a ^ sign_b) ? -w_lo : w_lo);
  assign rem  = sign_a ? -w_hi : w_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      md_busy <= 1'b0;
      cnt     <= '0;
      w_hi    <= '0;
      w_lo    <= '0;
      mb      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      div_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: if (md_start) begin
          sign_a  <= md_signed & bus_a[MSB];
          sign_b  <= md_signed & bus_b[MSB];
          div_q   <= md_div_op;
          w_hi    <= '0;
          w_lo    <= mag_a;
          mb      <= mag_b;
          cnt     <= '0;
          md_busy <= 1'b1;
`ifdef EX_FAST_MUL_EN
          state   <= md_div_op ? CALC : FIX;
`else
          state   <= CALC;
`endif
        end
        CALC: begin
          if (div_q) begin
            w_hi <= div_diff[XLEN] ? div_shift[MSB:0] : div_diff[MSB:0];
            w_lo <= {w_lo[MSB-1:0], ~div_diff[XLEN]};
          end else begin
            w_hi <= mul_sum[XLEN:1];
            w_lo <= {mul_sum[0], w_lo[MSB:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          if (div_q) begin
            hi <= rem;
            lo <= quot;
          end else begin
            hi <= prod[2*XLEN-1:XLEN];
            lo <= prod[MSB:0];
          end
          md_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: arithmetic reference model checked every cycle plus literal expectations.
module tb_ex_stage_md;
  localparam int XLEN  = 32;
  localparam int CTRLW = 8;
`ifdef EX_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 1'b0, flush = 1'b0, mem_stall = 1'b0;
  logic [3:0] alu_op = '0;
  logic alu_src = 1'b0, ext_op = 1'b0, reg_dst = 1'b1;
  logic [2:0] md_op = '0;
  logic [CTRLW-1:0] ctrl_in = 8'h5A;
  logic [XLEN-1:0] next_pc = 32'h200, bus_a = '0, bus_b = '0;
  logic [15:0] imm = '0;
  logic [4:0] rt = 5'd7, rd = 5'd3;
  logic ex_ready, ex_valid, zero, overflow, md_busy;
  logic [CTRLW-1:0] ctrl_ex;
  logic [XLEN-1:0] alu_out, tran_addr, reg_data;
  logic [4:0] regwr;

  ex_stage_md #(.XLEN(XLEN), .CTRLW(CTRLW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ex_ready(ex_ready), .flush(flush),
    .mem_stall(mem_stall), .alu_op(alu_op), .alu_src(alu_src), .ext_op(ext_op),
    .reg_dst(reg_dst), .md_op(md_op), .ctrl_in(ctrl_in), .next_pc(next_pc),
    .bus_a(bus_a), .bus_b(bus_b), .imm(imm), .rt(rt), .rd(rd), .ex_valid(ex_valid),
    .ctrl_ex(ctrl_ex), .alu_out(alu_out), .zero(zero), .overflow(overflow),
    .tran_addr(tran_addr), .regwr(regwr), .reg_data(reg_data), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what EX/MEM and HI/LO must hold, from plain arithmetic
  bit m_valid = 0, m_zero = 0, m_ovf = 0;
  logic [7:0]  m_ctrl = '0;
  logic [31:0] m_alu = '0, m_tran = '0, m_data = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic [4:0]  m_regwr = '0;
  int m_busy = 0;
  bit mb_now, m_acc, tmp_ovf;
  logic [31:0] m_ext, m_b;
  longint sprod;
  logic [63:0] uprod;

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output bit ovf);
    longint s;
    ovf = 0;
    case (op)
      4'd0: begin s = longint'($signed(a)) + longint'($signed(b)); ovf = (s != longint'($signed(s[31:0]))); return s[31:0]; end
      4'd1: begin s = longint'($signed(a)) - longint'($signed(b)); ovf = (s != longint'($signed(s[31:0]))); return s[31:0]; end
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_alu = '0; m_zero = 0; m_ovf = 0; m_tran = '0;
      m_regwr = '0; m_data = '0; m_hi = '0; m_lo = '0; m_busy = 0;
    end else begin
      mb_now = (m_busy != 0);
      m_acc  = id_valid && !mb_now && !mem_stall && !flush;
      if (mb_now) begin
        m_busy--;
        if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
      m_ext = ext_op ? {{16{imm[15]}}, imm} : {16'h0000, imm};
      m_b   = alu_src ? m_ext : bus_b;
      if (!mem_stall) begin
        if (m_acc && !(md_op inside {[3'd1:3'd4]})) begin
          m_valid = 1; m_ctrl = ctrl_in;
          if (md_op == 3'd5) begin m_alu = m_hi; m_ovf = 0; end
          else if (md_op == 3'd6) begin m_alu = m_lo; m_ovf = 0; end
          else begin m_alu = model_alu(alu_op, bus_a, m_b, tmp_ovf); m_ovf = tmp_ovf; end
          m_zero  = (m_alu == 0);
          m_tran  = next_pc + (m_ext << 2);
          m_regwr = reg_dst ? rd : rt;
          m_data  = bus_b;
        end else begin
          m_valid = 0; m_ctrl = '0;
        end
      end
      if (m_acc && (md_op inside {[3'd1:3'd4]})) begin
        case (md_op)
          3'd1: begin sprod = longint'($signed(bus_a)) * longint'($signed(bus_b)); p_hi = sprod[63:32]; p_lo = sprod[31:0]; end
          3'd2: begin uprod = {32'h0, bus_a} * {32'h0, bus_b}; p_hi = uprod[63:32]; p_lo = uprod[31:0]; end
          default: begin
            if (bus_b == 0) begin p_lo = 32'hFFFFFFFF; p_hi = bus_a; end
            else if (md_op == 3'd3 && bus_a == 32'h80000000 && bus_b == 32'hFFFFFFFF) begin p_lo = bus_a; p_hi = 0; end
            else if (md_op == 3'd3) begin p_lo = $signed(bus_a) / $signed(bus_b); p_hi = $signed(bus_a) % $signed(bus_b); end
            else begin p_lo = bus_a / bus_b; p_hi = bus_a % bus_b; end
          end
        endcase
        m_busy = (md_op <= 3'd2) ? MUL_CYC : DIV_CYC;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ex_valid", ex_valid, m_valid);
    chk("ctrl_ex", ctrl_ex, m_ctrl);
    chk("md_busy", md_busy, m_busy != 0);
    chk("ex_ready", ex_ready, (m_busy == 0) && !mem_stall);
    if (m_valid) begin
      chk("alu_out", alu_out, m_alu);
      chk("zero", zero, m_zero);
      chk("overflow", overflow, m_ovf);
      chk("tran_addr", tran_addr, m_tran);
      chk("regwr", regwr, m_regwr);
      chk("reg_data", reg_data, m_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic [3:0] op, input logic [2:0] md, input logic src, input logic eo,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
    alu_op = op; md_op = md; alu_src = src; ext_op = eo; bus_a = a; bus_b = b; imm = im;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] md, input logic src, input logic eo,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
    setop(op, md, src, eo, a, b, im);
    id_valid = 1'b1;
    step();
    id_valid = 1'b0;
  endtask

  task automatic wait_md(input string name, input int exp_cycles);
    int n = 0;
    while (md_busy === 1'b1 && n < 200) begin
      chk("ready_while_busy", ex_ready, 1'b0);
      n++;
      step();
    end
    chk(name, n, exp_cycles);
  endtask

  task automatic read_md(input logic [2:0] sel, input string name, input logic [31:0] exp);
    issue(4'd0, sel, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    chk(name, alu_out, exp);
  endtask

  task automatic held_mflo(input string name, input logic [31:0] exp, input int exp_wait);
    int n = 0;
    setop(4'd0, 3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    id_valid = 1'b1;
    while (ex_valid !== 1'b1 && n < 100) begin n++; step(); end
    id_valid = 1'b0;
    chk({name, "_wait"}, n, exp_wait);
    chk(name, alu_out, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    step(); step();
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_alu_out", alu_out, 32'h0);
    chk("rst_md_busy", md_busy, 1'b0);
    rst = 1'b0;
    step();

    issue(4'd0, 3'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1, 16'h0);
    chk("add_ovf_result", alu_out, 32'h80000000);
    chk("add_ovf_flag", overflow, 1'b1);
    chk("add_ovf_zero", zero, 1'b0);
    chk("add_ovf_valid", ex_valid, 1'b1);
    chk("add_ovf_regwr", regwr, 5'd3);

    next_pc = 32'h100; reg_dst = 1'b0;
    issue(4'd1, 3'd0, 1'b0, 1'b1, 32'd5, 32'd5, 16'hFFFF);
    chk("sub_zero", zero, 1'b1);
    chk("branch_target", tran_addr, 32'hFC);
    chk("regwr_rt", regwr, 5'd7);
    reg_dst = 1'b1; next_pc = 32'h200;

    issue(4'd8, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 16'h1234);
    chk("lui", alu_out, 32'h12340000);
    issue(4'd6, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 16'h0);
    chk("slt", alu_out, 32'h1);
    issue(4'd7, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 16'h0);
    chk("sltu", alu_out, 32'h0);
    issue(4'd5, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    issue(4'd1, 3'd0, 1'b0, 1'b0, 32'h80000000, 32'h1, 16'h0);
    chk("sub_ovf", overflow, 1'b1);
    issue(4'd12, 3'd0, 1'b0, 1'b0, 32'h1234, 32'h5678, 16'h0);
    chk("op12_zero", zero, 1'b1);

    issue(4'd0, 3'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h2, 16'h0);
    wait_md("mult_busy_cycles", MUL_CYC);
    read_md(3'd5, "mult_hi", 32'hFFFFFFFF);
    read_md(3'd6, "mult_lo", 32'hFFFFFFFE);

    issue(4'd0, 3'd3, 1'b0, 1'b0, 32'hFFFFFFF9, 32'h2, 16'h0);
    held_mflo("div_lo", 32'hFFFFFFFD, DIV_CYC + 1);
    read_md(3'd5, "div_hi", 32'hFFFFFFFF);

    issue(4'd0, 3'd4, 1'b0, 1'b0, 32'd9, 32'd0, 16'h0);
    wait_md("divu_busy_cycles", DIV_CYC);
    read_md(3'd6, "divu0_lo", 32'hFFFFFFFF);
    read_md(3'd5, "divu0_hi", 32'd9);

    issue(4'd0, 3'd3, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 16'h0);
    wait_md("divmin_busy", DIV_CYC);
    read_md(3'd6, "divmin_lo", 32'h80000000);
    read_md(3'd5, "divmin_hi", 32'h0);

    issue(4'd0, 3'd3, 1'b0, 1'b0, 32'hFFFFFFF9, 32'h0, 16'h0);
    wait_md("div0_busy", DIV_CYC);
    read_md(3'd6, "sdiv0_lo", 32'hFFFFFFFF);
    read_md(3'd5, "sdiv0_hi", 32'hFFFFFFF9);

    issue(4'd0, 3'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0);
    wait_md("multu_busy", MUL_CYC);
    read_md(3'd5, "multu_hi", 32'hFFFFFFFE);
    read_md(3'd6, "multu_lo", 32'h1);

    issue(4'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 16'h0);
    setop(4'd0, 3'd0, 1'b0, 1'b0, 32'd10, 32'd20, 16'h0);
    mem_stall = 1'b1; id_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", alu_out, 32'd3);
      chk("stall_ready", ex_ready, 1'b0);
    end
    mem_stall = 1'b0;
    step();
    chk("stall_release", alu_out, 32'd30);

    flush = 1'b1;
    step();
    chk("flush_bubble", ex_valid, 1'b0);
    chk("flush_ctrl", ctrl_ex, 8'h00);
    flush = 1'b0; id_valid = 1'b0;

    issue(4'd0, 3'd3, 1'b0, 1'b0, 32'd100, 32'd7, 16'h0);
    for (int i = 0; i < 9; i++) step();
    chk("pre_rst_busy", md_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", md_busy, 1'b0);
    chk("rst_mid_valid", ex_valid, 1'b0);
    step();
    rst = 1'b0;
    step();
    read_md(3'd5, "rst_hi", 32'h0);
    read_md(3'd6, "rst_lo", 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
